// File: rtl/keypad_scan_reader_if.sv
// Keypad-side and consumer-side signals of the matrix keypad scan reader.
interface keypad_scan_reader_if;
    logic [3:0] row_sense;
    logic [3:0] col_drive;
    logic [1:0] scan_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row_sense,
        output col_drive,
        output scan_col,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row_sense,
        input  col_drive,
        input  scan_col,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan_reader.sv
// 4x4 matrix keypad scanner: drives one column at a time, samples the rows into a
// 16-bit frame, and debounces the lowest pressed key over whole frames.
module keypad_scan_reader #(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                  clock,
    input  logic                  resetn,
    keypad_scan_reader_if.master  kp
);
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_e;

    logic [DIV_W-1:0] div_q;
    logic [1:0]       scan_col_q;
    logic [3:0]       col_drive_q;
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [15:0]      frame_q;
    logic [15:0]      frame_d;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       latched_q;
    logic [3:0]       key_code_q;
    logic             key_valid_q;
    logic             key_held_q;

    logic             tick_c;
    logic             frame_done_c;
    logic [3:0]       cand_c;
    logic             cand_none_c;
    logic             latched_set_c;

    assign tick_c        = (div_q == DIV_LAST);
    assign frame_done_c  = tick_c && (scan_col_q == 2'd3);
    assign latched_set_c = frame_d[latched_q];

    // Frame including the column being left on this tick (rows inverted: 1 = pressed)
    always_comb begin
        frame_d = frame_q;
        for (int r = 0; r < 4; r++) begin
            frame_d[{2'(r), scan_col_q}] = ~sync2_q[r];
        end
    end

    // Lowest pressed key index wins
    always_comb begin
        cand_c      = 4'd0;
        cand_none_c = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            if (frame_d[i]) begin
                cand_c      = 4'(i);
                cand_none_c = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            div_q       <= '0;
            scan_col_q  <= 2'd0;
            col_drive_q <= 4'b1110;
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            frame_q     <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            latched_q   <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            sync1_q     <= kp.row_sense;
            sync2_q     <= sync1_q;
            key_valid_q <= 1'b0;

            if (tick_c) begin
                div_q       <= '0;
                scan_col_q  <= scan_col_q + 2'd1;
                col_drive_q <= ~(4'b0001 << (scan_col_q + 2'd1));
                frame_q     <= frame_d;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end

            if (frame_done_c) begin
                case (state_q)
                    IDLE: begin
                        if (!cand_none_c) begin
                            latched_q <= cand_c;
                            cnt_q     <= CNT_W'(1);
                            state_q   <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (!cand_none_c && (cand_c == latched_q)) begin
                            if (cnt_q >= CNT_LAST) begin
                                cnt_q       <= CNT_MAX;
                                state_q     <= PRESSED;
                                key_code_q  <= latched_q;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end else begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end
                    end
                    PRESSED: begin
                        if (!latched_set_c) begin
                            cnt_q   <= CNT_W'(1);
                            state_q <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (latched_set_c) begin
                            cnt_q   <= '0;
                            state_q <= PRESSED;
                        end else if (cnt_q >= CNT_LAST) begin
                            cnt_q      <= '0;
                            state_q    <= IDLE;
                            key_held_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign kp.col_drive = col_drive_q;
    assign kp.scan_col  = scan_col_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scan_reader.sv
// Bench for keypad_scan_reader: frame-level key model, scoreboard of expected key reports.
module tb_keypad_scan_reader;
    localparam int unsigned SCAN_DIV = 4;
    localparam int          DEB      = 3;
    localparam int unsigned FRAME    = 16;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  code;
    } exp_t;

    logic        clock  = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] pressed = '0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        expq[$];

    // Frame-level model of the debounced key
    bit          m_held = 0;
    int          m_key  = 0;
    int          m_pend = 0;
    int          m_run  = 0;
    int          m_rel  = 0;
    int          m_code = 0;

    keypad_scan_reader_if kp();

    keypad_scan_reader #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .kp     (kp)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Keypad matrix: a row reads low while a pressed key sits in the driven column
    always_comb begin
        kp.row_sense = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[{2'(r), 2'(c)}] && !kp.col_drive[2'(c)])
                    kp.row_sense[2'(r)] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int lowest(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_held = 0; m_run = 0; m_rel = 0; m_code = 0; m_pend = 0; m_key = 0;
    endtask

    task automatic model_frame(input logic [15:0] m, output bit rep);
        int c;
        c = lowest(m);
        rep = 0;
        if (m_held) begin
            if (!m[4'(m_key)]) begin
                m_rel++;
                if (m_rel >= DEB) begin
                    m_held = 0; m_rel = 0; m_run = 0;
                end
            end else begin
                m_rel = 0;
            end
        end else if (m_run > 0) begin
            if (c == m_pend) begin
                m_run++;
                if (m_run >= DEB) begin
                    rep = 1; m_held = 1; m_key = m_pend; m_code = m_pend;
                    m_run = 0; m_rel = 0;
                end
            end else begin
                m_run = 0;
            end
        end else if (c >= 0) begin
            m_pend = c;
            m_run  = 1;
        end
    endtask

    // Scoreboard monitor: every key_valid pulse must match the next expected report
    always @(negedge clock) begin
        if (resetn && kp.key_valid === 1'b1) begin
            if (expq.size() == 0) begin
                check("unexpected_key_valid", {28'd0, kp.key_code}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("valid_cycle", cyc, e.cyc);
                check("valid_code", {28'd0, kp.key_code}, {28'd0, e.code});
                check("held_at_valid", {31'd0, kp.key_held}, 32'd1);
            end
        end
    end

    // Called at a negedge on a frame boundary
    task automatic run_frame(input logic [15:0] m);
        bit   rep;
        exp_t e;
        check("held", {31'd0, kp.key_held}, {31'd0, m_held});
        if (m_held) check("code_while_held", {28'd0, kp.key_code}, 32'(m_code));
        pressed = m;
        model_frame(m, rep);
        if (rep) begin
            e.cyc  = cyc + FRAME;
            e.code = 4'(m_code);
            expq.push_back(e);
        end
        repeat (FRAME) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run_frames(input logic [15:0] m, input int n);
        for (int i = 0; i < n; i++) run_frame(m);
    endtask

    task automatic do_reset(input int n);
        check("pending_reports_at_reset", expq.size(), 0);
        expq.delete();
        resetn = 1'b0;
        repeat (n) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        model_reset();
        check("rst_col_drive", {28'd0, kp.col_drive}, 32'hE);
        check("rst_scan_col", {30'd0, kp.scan_col}, 32'd0);
        check("rst_key_code", {28'd0, kp.key_code}, 32'd0);
        check("rst_key_valid", {31'd0, kp.key_valid}, 32'd0);
        check("rst_key_held", {31'd0, kp.key_held}, 32'd0);
    endtask

    initial begin
        logic [15:0] m;
        logic [15:0] one;
        int          n;
        one = 16'd1;
        @(negedge clock);

        // Idle scan: columns rotate every SCAN_DIV clocks, nothing reported
        pressed = '0;
        do_reset(2);
        for (int j = 0; j < 32; j++) begin
            m = ~(one << ((j / 4) % 4));
            check("idle_col_drive", {28'd0, kp.col_drive}, {28'd0, m[3:0]});
            check("idle_scan_col", {30'd0, kp.scan_col}, 32'((j / 4) % 4));
            check("idle_key_valid", {31'd0, kp.key_valid}, 32'd0);
            check("idle_key_held", {31'd0, kp.key_held}, 32'd0);
            check("idle_key_code", {28'd0, kp.key_code}, 32'd0);
            @(posedge clock);
            @(negedge clock);
        end

        // Key 9 pressed and released
        run_frames(one << 9, 5);
        run_frames('0, 4);

        // Bouncing key 9: never reported
        for (int i = 0; i < 5; i++) begin
            run_frame(one << 9);
            run_frame('0);
        end
        run_frames('0, 2);

        // Keys 5 and 10 together, then release 5 while 10 stays down
        run_frames((one << 5) | (one << 10), 4);
        run_frames(one << 10, 7);
        run_frames('0, 4);

        // Key 9 released briefly then pressed again: no second report
        run_frames(one << 9, 4);
        run_frames('0, 2);
        run_frames(one << 9, 3);
        run_frames('0, 4);

        // Reset while held: key re-reported once, release produces nothing
        run_frames(one << 9, 4);
        do_reset(1);
        run_frames(one << 9, 4);
        run_frames('0, 4);

        // Randomised key activity
        for (int s = 0; s < 60; s++) begin
            case ($urandom_range(0, 3))
                0: m = '0;
                1: m = one << $urandom_range(0, 15);
                2: m = (one << $urandom_range(0, 15)) | (one << $urandom_range(0, 15));
                default: m = 16'($urandom);
            endcase
            n = int'($urandom_range(1, 5));
            run_frames(m, n);
            if ($urandom_range(0, 14) == 0) do_reset(1);
        end

        run_frames('0, 4);
        check("missing_reports", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
